// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
//
// Shared definitions for the camera capture path.
//   - cam_state_t       : capture FSM encoding (also exported on the debug port)
//   - CAM_DATA_W        : output pixel width (RGB444)
//   - CAM_IMG_W/H       : default frame geometry
//   - rgb565_to_rgb444  : byte-pair to RGB444 bit-slice
// -----------------------------------------------------------------------------
package cam_pkg;

    localparam int CAM_DATA_W = 12;
    localparam int CAM_IMG_W  = 640;
    localparam int CAM_IMG_H  = 480;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,  // capture disabled
        ST_WAIT_VS  = 2'd1,  // enabled, waiting for a frame boundary
        ST_WAIT_SOF = 2'd2,  // inside VSYNC, waiting for the frame to start
        ST_CAPTURE  = 2'd3   // pairing bytes and writing pixels
    } cam_state_t;

    // hi is the first byte of a pixel, lo the second (RGB565 on the wire).
    //   R = hi[7:4], G = {hi[2:0], lo[7]}, B = lo[4:1]
    function automatic logic [CAM_DATA_W-1:0] rgb565_to_rgb444(
        input logic [7:0] hi,
        input logic [7:0] lo
    );
        return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// -----------------------------------------------------------------------------
// cam_sync_edge
//
// Registers the DVP bus once and derives the frame/line edge strobes from the
// registered copies. All downstream decisions use these outputs only.
//
// Ports:
//   i_clk, i_rstn   pixel clock, async active-low reset
//   i_vsync         raw camera VSYNC
//   i_href          raw camera HREF
//   i_data[7:0]     raw camera data byte
//   o_href          registered HREF
//   o_data[7:0]     registered data byte
//   o_vs_rise       registered VSYNC 0->1 (end of frame / start of gap)
//   o_vs_fall       registered VSYNC 1->0 (frame about to start)
//   o_href_fall     registered HREF 1->0 (end of line)
// -----------------------------------------------------------------------------
module cam_sync_edge (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_vsync,
    input  logic       i_href,
    input  logic [7:0] i_data,
    output logic       o_href,
    output logic [7:0] o_data,
    output logic       o_vs_rise,
    output logic       o_vs_fall,
    output logic       o_href_fall
);

    logic       vsync_r;
    logic       vsync_q;   // previous value of vsync_r
    logic       href_r;
    logic       href_q;    // previous value of href_r
    logic [7:0] data_r;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            vsync_r <= 1'b0;
            vsync_q <= 1'b0;
            href_r  <= 1'b0;
            href_q  <= 1'b0;
            data_r  <= 8'h00;
        end else begin
            vsync_r <= i_vsync;
            vsync_q <= vsync_r;
            href_r  <= i_href;
            href_q  <= href_r;
            data_r  <= i_data;
        end
    end

    assign o_href      = href_r;
    assign o_data      = data_r;
    assign o_vs_rise   =  vsync_r & ~vsync_q;
    assign o_vs_fall   = ~vsync_r &  vsync_q;
    assign o_href_fall = ~href_r  &  href_q;

endmodule

// File: rtl/cam_capture.sv
// -----------------------------------------------------------------------------
// cam_capture
//
// Pixel-clock capture stage: samples the camera DVP bus, pairs RGB565 bytes
// into pixels, reduces them to RGB444 and writes them into the preprocess
// FIFO. Capture only ever starts on a frame boundary; every captured frame is
// checked for IMG_H lines of IMG_W pixels with no dropped pixels.
//
// FIFO write interface: o_wr is a one-cycle write strobe carrying o_wdata.
// It is only raised when i_full is low in the cycle the pixel completes; the
// camera cannot be stalled, so a pixel that meets i_full is dropped and
// recorded in o_overflow (sticky until reset) and in that frame's o_frame_ok.
//
// Ports:
//   i_clk, i_rstn       pixel clock, async active-low reset
//   i_start             capture enable (level), acted on at frame boundaries
//   i_vsync, i_href     camera sync inputs
//   i_data[7:0]         camera data byte
//   o_wr, o_wdata       FIFO write strobe / pixel {R,G,B} 4 bits each
//   i_full              FIFO full flag
//   o_sof, o_eof        one-cycle start / end of captured frame
//   o_frame_ok          geometry/drop verdict, valid with o_eof
//   o_overflow          sticky pixel-drop flag
//   o_state             current FSM state (debug)
// -----------------------------------------------------------------------------
module cam_capture
    import cam_pkg::*;
#(
    parameter int DATA_WIDTH = CAM_DATA_W,  // must stay 12 (RGB444)
    parameter int IMG_W      = CAM_IMG_W,
    parameter int IMG_H      = CAM_IMG_H
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic                  i_vsync,
    input  logic                  i_href,
    input  logic [7:0]            i_data,
    output logic                  o_wr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    input  logic                  i_full,
    output logic                  o_sof,
    output logic                  o_eof,
    output logic                  o_frame_ok,
    output logic                  o_overflow,
    output logic [1:0]            o_state
);

    // One spare count above the expected value so an oversize line/frame
    // saturates at an illegal count instead of wrapping back to a legal one.
    localparam int PW = $clog2(IMG_W + 2);
    localparam int LW = $clog2(IMG_H + 2);

    localparam logic [PW-1:0] PIX_EXP  = PW'(IMG_W);
    localparam logic [PW-1:0] PIX_MAX  = PW'(IMG_W + 1);
    localparam logic [LW-1:0] LINE_EXP = LW'(IMG_H);
    localparam logic [LW-1:0] LINE_MAX = LW'(IMG_H + 1);

    // Registered camera bus and edge strobes
    logic       href;
    logic [7:0] data;
    logic       vs_rise;
    logic       vs_fall;
    logic       href_fall;

    cam_sync_edge u_sync (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_vsync     (i_vsync),
        .i_href      (i_href),
        .i_data      (i_data),
        .o_href      (href),
        .o_data      (data),
        .o_vs_rise   (vs_rise),
        .o_vs_fall   (vs_fall),
        .o_href_fall (href_fall)
    );

    cam_state_t      state;
    logic            phase;      // 0: expecting first byte, 1: second byte
    logic [7:0]      hi_byte;
    logic [PW-1:0]   pix_cnt;
    logic [LW-1:0]   line_cnt;
    logic            frame_err;

    logic            pairing;
    logic [PW-1:0]   pix_cnt_inc;
    logic            line_end;
    logic            line_bad;
    logic [LW-1:0]   line_cnt_nxt;
    logic            frame_good;

    always_comb begin
        pairing      = (state == ST_CAPTURE) && href;
        pix_cnt_inc  = (pix_cnt == PIX_MAX) ? pix_cnt : pix_cnt + PW'(1);
        line_end     = (state == ST_CAPTURE) && href_fall;
        // phase is still the parity of the finished line here: 1 = odd bytes
        line_bad     = line_end && ((pix_cnt != PIX_EXP) || phase);
        line_cnt_nxt = line_cnt;
        if (line_end && (line_cnt != LINE_MAX)) begin
            line_cnt_nxt = line_cnt + LW'(1);
        end
        // A line ending on the same cycle as the frame still counts, and a
        // line still open (href high) at the frame end is a truncated line.
        frame_good   = !frame_err && !line_bad && !href &&
                       (line_cnt_nxt == LINE_EXP);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= ST_IDLE;
            phase      <= 1'b0;
            hi_byte    <= 8'h00;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            frame_err  <= 1'b0;
            o_wr       <= 1'b0;
            o_wdata    <= '0;
            o_sof      <= 1'b0;
            o_eof      <= 1'b0;
            o_frame_ok <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_wr       <= 1'b0;
            o_sof      <= 1'b0;
            o_eof      <= 1'b0;
            o_frame_ok <= 1'b0;

            // Byte pairing
            if (pairing) begin
                phase <= ~phase;
                if (!phase) begin
                    hi_byte <= data;
                end else begin
                    // Counted even when dropped so the line check still sees
                    // the true line length.
                    pix_cnt <= pix_cnt_inc;
                    if (i_full) begin
                        o_overflow <= 1'b1;
                        frame_err  <= 1'b1;
                    end else begin
                        o_wr    <= 1'b1;
                        o_wdata <= rgb565_to_rgb444(hi_byte, data);
                    end
                end
            end else begin
                phase <= 1'b0;
            end

            // Line bookkeeping
            if (line_end) begin
                if (line_bad) begin
                    frame_err <= 1'b1;
                end
                line_cnt <= line_cnt_nxt;
                pix_cnt  <= '0;
            end

            // Frame sequencing
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state <= ST_WAIT_VS;
                    end
                end
                ST_WAIT_VS: begin
                    // Enabling mid-frame must skip the rest of that frame.
                    if (vs_rise) begin
                        state <= ST_WAIT_SOF;
                    end
                end
                ST_WAIT_SOF: begin
                    if (vs_fall) begin
                        o_sof     <= 1'b1;
                        pix_cnt   <= '0;
                        line_cnt  <= '0;
                        frame_err <= 1'b0;
                        phase     <= 1'b0;
                        state     <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (vs_rise) begin
                        o_eof      <= 1'b1;
                        o_frame_ok <= frame_good;
                        state      <= i_start ? ST_WAIT_SOF : ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_cam_capture.sv
// -----------------------------------------------------------------------------
// tb_cam_capture
//
// Directed bench for cam_capture with a 4x3 frame geometry. The camera is
// driven on the falling clock edge; a monitor on the falling edge pops the
// expected pixel queue on every write and the expected verdict queue on every
// end of frame.
// -----------------------------------------------------------------------------
module tb_cam_capture;
    import cam_pkg::*;

    localparam int IMG_W = 4;
    localparam int IMG_H = 3;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        full;
    logic        wr;
    logic [11:0] wdata;
    logic        sof;
    logic        eof;
    logic        frame_ok;
    logic        overflow;
    logic [1:0]  state;

    always #5 clk = ~clk;

    cam_capture #(
        .DATA_WIDTH (12),
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_start    (start),
        .i_vsync    (vsync),
        .i_href     (href),
        .i_data     (data),
        .o_wr       (wr),
        .o_wdata    (wdata),
        .i_full     (full),
        .o_sof      (sof),
        .o_eof      (eof),
        .o_frame_ok (frame_ok),
        .o_overflow (overflow),
        .o_state    (state)
    );

    // ---------------- scoreboard ----------------
    logic [11:0] exp_q[$];
    logic        ok_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;
    int sof_cnt  = 0;
    int eof_cnt  = 0;
    bit capt_en  = 1'b0;   // pixels driven now are expected to be captured

    // Hand-computed RGB444 results for the byte pairs below
    logic [7:0]  hi_tab  [4] = '{8'hF8, 8'h07, 8'hA5, 8'h3C};
    logic [7:0]  lo_tab  [4] = '{8'h1F, 8'hE0, 8'h5A, 8'hC3};
    logic [11:0] exp_tab [4] = '{12'hF0F, 12'h0F0, 12'hAAD, 12'h391};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (wr) begin
            wr_cnt++;
            if (exp_q.size() == 0) check("wr_spurious", 32'(wr), 32'd0);
            else                   check("wdata", 32'(wdata), 32'(exp_q.pop_front()));
        end
        if (sof) sof_cnt++;
        if (eof) begin
            eof_cnt++;
            if (ok_q.size() == 0) check("eof_spurious", 32'(eof), 32'd0);
            else                  check("frame_ok", 32'(frame_ok), 32'(ok_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [7:0] pix_hi(input int mode, input int p);
        return (mode == 0) ? 8'hF8 : hi_tab[p % 4];
    endfunction

    function automatic logic [7:0] pix_lo(input int mode, input int p);
        return (mode == 0) ? 8'h1F : lo_tab[p % 4];
    endfunction

    function automatic logic [11:0] pix_exp(input int mode, input int p);
        return (mode == 0) ? 12'hF0F : exp_tab[p % 4];
    endfunction

    task automatic vs_pulse();
        @(negedge clk); vsync = 1'b1; href = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // full_pix: pixel (in line) that completes while i_full is high, -1 none
    // start_byte: byte index at which i_start is driven to start_val, -1 none
    task automatic drive_line(input int nbytes, input int mode, input int full_pix,
                              input int start_byte, input logic start_val);
        for (int b = 0; b < nbytes; b++) begin
            @(negedge clk);
            href = 1'b1;
            data = (b % 2 == 0) ? pix_hi(mode, b / 2) : pix_lo(mode, b / 2);
            // The pixel completes in the cycle after its second byte.
            full = (full_pix >= 0) && (b == 2 * full_pix + 1 || b == 2 * full_pix + 2);
            if (start_byte >= 0 && b == start_byte) start = start_val;
            if ((b % 2 == 1) && capt_en && (b / 2 != full_pix))
                exp_q.push_back(pix_exp(mode, b / 2));
        end
        @(negedge clk); href = 1'b0; data = 8'h00; full = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic drive_frame(input int mode, input int n_lines,
                               input int odd_line, input int odd_bytes,
                               input int full_line, input int full_pix,
                               input int start_line, input int start_byte,
                               input logic start_val, input logic ok);
        for (int l = 0; l < n_lines; l++) begin
            drive_line((l == odd_line) ? odd_bytes : 2 * IMG_W, mode,
                       (l == full_line) ? full_pix : -1,
                       (l == start_line) ? start_byte : -1, start_val);
        end
        if (capt_en) ok_q.push_back(ok);
    endtask

    task automatic clean_frame(input int mode);
        drive_frame(mode, IMG_H, -1, 0, -1, -1, -1, -1, 1'b0, 1'b1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    int w0, s0, e0;

    initial begin
        rstn = 1'b0; start = 1'b0; vsync = 1'b0; href = 1'b0;
        data = 8'h00; full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr",       32'(wr),       32'd0);
        check("rst_sof",      32'(sof),      32'd0);
        check("rst_eof",      32'(eof),      32'd0);
        check("rst_frame_ok", 32'(frame_ok), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_state",    32'(state),    32'(ST_IDLE));
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal: two 4x3 frames of F8/1F
        start = 1'b1; capt_en = 1'b1;
        repeat (2) @(negedge clk);
        check("nom_wait_vs", 32'(state), 32'(ST_WAIT_VS));
        w0 = wr_cnt; s0 = sof_cnt; e0 = eof_cnt;
        vs_pulse();
        check("nom_capture", 32'(state), 32'(ST_CAPTURE));
        clean_frame(0);
        vs_pulse();
        clean_frame(0);
        vs_pulse();
        check("nom_writes", 32'(wr_cnt - w0), 32'd24);
        check("nom_sof",    32'(sof_cnt - s0), 32'd3);
        check("nom_eof",    32'(eof_cnt - e0), 32'd2);
        check("nom_no_ovf", 32'(overflow), 32'd0);

        // Overflow on 3rd pixel, then a clean frame
        w0 = wr_cnt;
        drive_frame(1, IMG_H, -1, 0, 0, 2, -1, -1, 1'b0, 1'b0);
        vs_pulse();
        check("ovf_writes", 32'(wr_cnt - w0), 32'd11);
        check("ovf_flag",   32'(overflow), 32'd1);
        clean_frame(1);
        vs_pulse();
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Geometry errors, each followed by the next frame
        drive_frame(1, IMG_H, 1, 6, -1, -1, -1, -1, 1'b0, 1'b0);  // short line
        vs_pulse();
        drive_frame(1, 2, -1, 0, -1, -1, -1, -1, 1'b0, 1'b0);     // two lines
        vs_pulse();
        drive_frame(1, IMG_H, 2, 9, -1, -1, -1, -1, 1'b0, 1'b0);  // odd bytes
        vs_pulse();
        clean_frame(1);
        vs_pulse();
        check("geo_q_empty", 32'(ok_q.size()), 32'd0);

        // Stop mid-frame: frame completes, back to IDLE, no new sof
        s0 = sof_cnt; e0 = eof_cnt;
        drive_frame(1, IMG_H, -1, 0, -1, -1, 1, 2, 1'b0, 1'b1);
        vs_pulse();
        check("stop_eof",   32'(eof_cnt - e0), 32'd1);
        check("stop_idle",  32'(state), 32'(ST_IDLE));
        capt_en = 1'b0;
        w0 = wr_cnt;
        clean_frame(1);
        vs_pulse();
        check("stop_no_sof", 32'(sof_cnt - s0), 32'd0);
        check("stop_no_wr",  32'(wr_cnt - w0), 32'd0);

        // Enable mid-frame: rest of the frame ignored, next frame captured
        w0 = wr_cnt; s0 = sof_cnt; e0 = eof_cnt;
        drive_frame(1, IMG_H, -1, 0, -1, -1, 1, 3, 1'b1, 1'b1);
        check("mid_wait_vs", 32'(state), 32'(ST_WAIT_VS));
        check("mid_no_wr",   32'(wr_cnt - w0), 32'd0);
        vs_pulse();
        check("mid_sof",     32'(sof_cnt - s0), 32'd1);
        check("mid_no_eof",  32'(eof_cnt - e0), 32'd0);
        capt_en = 1'b1;
        clean_frame(1);
        vs_pulse();
        check("mid_eof",     32'(eof_cnt - e0), 32'd1);
        check("mid_writes",  32'(wr_cnt - w0), 32'd12);

        // Async reset between the hi and lo bytes of the third pixel
        w0 = wr_cnt;
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            href = 1'b1;
            data = (b % 2 == 0) ? pix_hi(1, b / 2) : pix_lo(1, b / 2);
            if (b % 2 == 1) exp_q.push_back(pix_exp(1, b / 2));
        end
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        check("arst_wr",       32'(wr),       32'd0);
        check("arst_wdata",    32'(wdata),    32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        check("arst_sof",      32'(sof),      32'd0);
        check("arst_state",    32'(state),    32'(ST_IDLE));
        check("arst_pending",  32'(exp_q.size()), 32'd0);
        check("arst_writes",   32'(wr_cnt - w0), 32'd2);
        href = 1'b0; data = 8'h00;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_wait_vs",  32'(state), 32'(ST_WAIT_VS));
        check("arst_no_wr",    32'(wr_cnt - w0), 32'd2);
        e0 = eof_cnt;
        vs_pulse();
        clean_frame(0);
        vs_pulse();
        check("arst_eof",      32'(eof_cnt - e0), 32'd1);
        check("arst_writes2",  32'(wr_cnt - w0), 32'd14);

        repeat (4) @(negedge clk);
        check("end_exp_q", 32'(exp_q.size()), 32'd0);
        check("end_ok_q",  32'(ok_q.size()),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
